// File: rtl/prio_arb_pkg.sv
// Shared types and constants for the request arbiter.
//   arb_mode_e  : ARB_FIXED (lowest index always wins) / ARB_RR (rotating priority)
//   arb_state_e : ST_IDLE (no grant presented) / ST_GRANT (grant held until ack)
//   ARB_MAX_REQ : largest supported requester count
package prio_arb_pkg;

  typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_e;
  typedef enum logic {ST_IDLE, ST_GRANT} arb_state_e;

  localparam int unsigned ARB_MAX_REQ = 32;

endpackage

// File: rtl/prio_pick.sv
// Combinational lowest-index-wins picker.
// Ports:
//   vec    in  [N-1:0]      candidate vector
//   found  out              at least one bit of vec is set
//   idx    out [IDX_W-1:0]  index of the lowest set bit (0 when none)
//   onehot out [N-1:0]      one-hot of the lowest set bit (0 when none)
module prio_pick #(
  parameter int unsigned N = 4,
  localparam int unsigned IDX_W = ($clog2(N) > 0) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     vec,
  output logic             found,
  output logic [IDX_W-1:0] idx,
  output logic [N-1:0]     onehot
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    found  = 1'b0;
    idx    = '0;
    onehot = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (vec[i]) begin
        found  = 1'b1;
        idx    = IDX_W'(i);
        onehot = N'(1) << i;
      end
    end
  end

endmodule

// File: rtl/prio_arbiter_rr.sv
// N-way request arbiter with registered, handshaked grant.
// A grant is held stable until ack; on ack the next grant is chosen in the
// same cycle so back-to-back grants have no idle bubble.
// Optional statistics: define PRIO_ARBITER_STATS_EN to add grant_cnt/wait_max.
// Ports:
//   clock      in               system clock (rising edge)
//   reset      in               synchronous, active-high reset
//   req        in  [N_REQ-1:0]  request vector
//   ack        in               consumer accepts the current grant
//   gnt_valid  out              a grant is presented
//   gnt_onehot out [N_REQ-1:0]  one-hot grant, 0 when no grant
//   gnt_idx    out [IDX_W-1:0]  binary grant index, 0 when no grant
//   busy       out              high while a grant is presented
//   grant_cnt  out [15:0]       (stats) accepted grants, saturating
//   wait_max   out [7:0]        (stats) longest grant duration in cycles, saturating
module prio_arbiter_rr
  import prio_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter arb_mode_e   MODE  = ARB_RR,
  localparam int unsigned IDX_W = ($clog2(N_REQ) > 0) ? $clog2(N_REQ) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             ack,
  output logic             gnt_valid,
  output logic [N_REQ-1:0] gnt_onehot,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             busy
`ifdef PRIO_ARBITER_STATS_EN
  ,
  output logic [15:0]      grant_cnt,
  output logic [7:0]       wait_max
`endif
);

  arb_state_e       r_state;
  logic [IDX_W-1:0] r_rr_ptr;

  logic [IDX_W-1:0] w_ptr_next;
  logic [IDX_W-1:0] w_ptr_eff;
  logic             w_accept;
  logic [N_REQ-1:0] w_req_masked;

  logic             w_m_found, w_a_found, w_found;
  logic [IDX_W-1:0] w_m_idx, w_a_idx, w_sel_idx;
  logic [N_REQ-1:0] w_m_onehot, w_a_onehot, w_sel_onehot;

  assign w_accept = (r_state == ST_GRANT) && ack;

  // Wrap on N_REQ-1 rather than the index width so non-power-of-two counts rotate correctly.
  assign w_ptr_next = (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  // On an accept the advanced pointer is used immediately, which also places
  // the just-served requester last in the rotation.
  assign w_ptr_eff = ((MODE == ARB_RR) && w_accept) ? w_ptr_next : r_rr_ptr;

  always_comb begin
    w_req_masked = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      w_req_masked[i] = req[i] && (IDX_W'(i) >= w_ptr_eff);
    end
  end

  prio_pick #(.N(N_REQ)) u_pick_masked (
    .vec    (w_req_masked),
    .found  (w_m_found),
    .idx    (w_m_idx),
    .onehot (w_m_onehot)
  );

  prio_pick #(.N(N_REQ)) u_pick_all (
    .vec    (req),
    .found  (w_a_found),
    .idx    (w_a_idx),
    .onehot (w_a_onehot)
  );

  // Masked pick first, unmasked pick provides the wrap-around.
  always_comb begin
    w_found      = w_a_found;
    w_sel_idx    = w_a_idx;
    w_sel_onehot = w_a_onehot;
    if ((MODE == ARB_RR) && w_m_found) begin
      w_sel_idx    = w_m_idx;
      w_sel_onehot = w_m_onehot;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= '0;
      gnt_valid  <= 1'b0;
      gnt_onehot <= '0;
      gnt_idx    <= '0;
      busy       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state    <= ST_GRANT;
            gnt_valid  <= 1'b1;
            busy       <= 1'b1;
            gnt_onehot <= w_sel_onehot;
            gnt_idx    <= w_sel_idx;
          end
        end
        ST_GRANT: begin
          // No pre-emption: outputs only move on ack.
          if (ack) begin
            if (MODE == ARB_RR) begin
              r_rr_ptr <= w_ptr_next;
            end
            if (w_found) begin
              gnt_onehot <= w_sel_onehot;
              gnt_idx    <= w_sel_idx;
            end else begin
              r_state    <= ST_IDLE;
              gnt_valid  <= 1'b0;
              busy       <= 1'b0;
              gnt_onehot <= '0;
              gnt_idx    <= '0;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef PRIO_ARBITER_STATS_EN
  logic [7:0] r_wait;
  logic       w_issue;

  assign w_issue = w_found && ((r_state == ST_IDLE) || w_accept);

  // r_wait counts cycles of the current grant, starting at 1 on the first presented cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      grant_cnt <= '0;
      wait_max  <= '0;
      r_wait    <= '0;
    end else begin
      if (w_accept) begin
        if (grant_cnt != 16'hFFFF) begin
          grant_cnt <= grant_cnt + 16'd1;
        end
        if (r_wait > wait_max) begin
          wait_max <= r_wait;
        end
      end
      if (w_issue) begin
        r_wait <= 8'd1;
      end else if (gnt_valid && !ack && (r_wait != 8'hFF)) begin
        r_wait <= r_wait + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_prio_arbiter_rr.sv
module tb_prio_arbiter_rr;

  logic       clock = 1'b0;
  logic       reset;
  logic       ack;
  logic [3:0] req;

  logic       rr_valid, rr_busy;
  logic [3:0] rr_onehot;
  logic [1:0] rr_idx;
  logic       fx_valid, fx_busy;
  logic [3:0] fx_onehot;
  logic [1:0] fx_idx;
  logic       n3_valid, n3_busy;
  logic [2:0] n3_onehot;
  logic [1:0] n3_idx;
`ifdef PRIO_ARBITER_STATS_EN
  logic [15:0] rr_cnt;
  logic [7:0]  rr_wmax;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  prio_arbiter_rr #(.N_REQ(4), .MODE(prio_arb_pkg::ARB_RR)) dut_rr (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .ack        (ack),
    .gnt_valid  (rr_valid),
    .gnt_onehot (rr_onehot),
    .gnt_idx    (rr_idx),
    .busy       (rr_busy)
`ifdef PRIO_ARBITER_STATS_EN
    ,
    .grant_cnt  (rr_cnt),
    .wait_max   (rr_wmax)
`endif
  );

  prio_arbiter_rr #(.N_REQ(4), .MODE(prio_arb_pkg::ARB_FIXED)) dut_fx (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .ack        (ack),
    .gnt_valid  (fx_valid),
    .gnt_onehot (fx_onehot),
    .gnt_idx    (fx_idx),
    .busy       (fx_busy)
`ifdef PRIO_ARBITER_STATS_EN
    ,
    .grant_cnt  (),
    .wait_max   ()
`endif
  );

  prio_arbiter_rr #(.N_REQ(3), .MODE(prio_arb_pkg::ARB_RR)) dut_n3 (
    .clock      (clock),
    .reset      (reset),
    .req        (req[2:0]),
    .ack        (ack),
    .gnt_valid  (n3_valid),
    .gnt_onehot (n3_onehot),
    .gnt_idx    (n3_idx),
    .busy       (n3_busy)
`ifdef PRIO_ARBITER_STATS_EN
    ,
    .grant_cnt  (),
    .wait_max   ()
`endif
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0000;
    ack   = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({rr_valid, rr_onehot, rr_idx, rr_busy} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_state: got %b expected 00000000", {rr_valid, rr_onehot, rr_idx, rr_busy});
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      vectors++;
      if ({rr_valid, rr_onehot, rr_idx, rr_busy, fx_valid, fx_onehot, fx_idx, fx_busy} !== 16'h0000) begin
        miscompares++;
        $display("FAIL idle_no_req cycle %0d: got rr=%b fx=%b expected all zero", k,
                 {rr_valid, rr_onehot, rr_idx, rr_busy}, {fx_valid, fx_onehot, fx_idx, fx_busy});
      end
    end
  endtask

  task automatic test_fixed();
    do_reset();
    req = 4'b1110;
    tick();
    vectors++;
    if (fx_valid !== 1'b1 || fx_idx !== 2'd1 || fx_onehot !== 4'b0010 || fx_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL fixed_first: got v=%b idx=%0d oh=%b expected v=1 idx=1 oh=0010", fx_valid, fx_idx, fx_onehot);
    end
    ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if (fx_valid !== 1'b1 || fx_idx !== 2'd1 || fx_onehot !== 4'b0010) begin
        miscompares++;
        $display("FAIL fixed_repeat %0d: got v=%b idx=%0d expected v=1 idx=1", k, fx_valid, fx_idx);
      end
    end
    req = 4'b1111;
    tick();
    vectors++;
    if (fx_valid !== 1'b1 || fx_idx !== 2'd0 || fx_onehot !== 4'b0001) begin
      miscompares++;
      $display("FAIL fixed_idx0: got v=%b idx=%0d oh=%b expected v=1 idx=0 oh=0001", fx_valid, fx_idx, fx_onehot);
    end
    ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    int exp_seq [5] = '{1, 3, 0, 1, 3};
    do_reset();
    req = 4'b1011;
    tick();
    vectors++;
    if (rr_valid !== 1'b1 || rr_idx !== 2'd0) begin
      miscompares++;
      $display("FAIL rr_first: got v=%b idx=%0d expected v=1 idx=0", rr_valid, rr_idx);
    end
    ack = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      vectors++;
      if (rr_valid !== 1'b1 || rr_idx !== 2'(exp_seq[k]) || rr_onehot !== (4'b0001 << exp_seq[k])) begin
        miscompares++;
        $display("FAIL rr_b2b step %0d: got v=%b idx=%0d oh=%b expected v=1 idx=%0d", k, rr_valid, rr_idx, rr_onehot, exp_seq[k]);
      end
    end
    ack = 1'b0;
  endtask

  task automatic test_no_preempt();
    do_reset();
    req = 4'b0100;
    tick();
    req = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (rr_valid !== 1'b1 || rr_idx !== 2'd2 || rr_onehot !== 4'b0100) begin
        miscompares++;
        $display("FAIL hold_grant cycle %0d: got v=%b idx=%0d oh=%b expected v=1 idx=2 oh=0100", k, rr_valid, rr_idx, rr_onehot);
      end
      tick();
    end
    ack = 1'b1;
    tick();
    vectors++;
    if (rr_valid !== 1'b1 || rr_idx !== 2'd0 || rr_onehot !== 4'b0001) begin
      miscompares++;
      $display("FAIL after_hold: got v=%b idx=%0d oh=%b expected v=1 idx=0 oh=0001", rr_valid, rr_idx, rr_onehot);
    end
    ack = 1'b0;
  endtask

  task automatic test_idle_ack_and_drop();
    do_reset();
    ack = 1'b1;
    tick();
    vectors++;
    if (rr_valid !== 1'b0 || rr_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_ack: got v=%b busy=%b expected 0 0", rr_valid, rr_busy);
    end
    req = 4'b0010;
    tick();
    vectors++;
    if (rr_valid !== 1'b1 || rr_idx !== 2'd1) begin
      miscompares++;
      $display("FAIL grant_from_idle: got v=%b idx=%0d expected v=1 idx=1", rr_valid, rr_idx);
    end
    tick();
    vectors++;
    if (rr_valid !== 1'b1 || rr_idx !== 2'd1) begin
      miscompares++;
      $display("FAIL regrant_sole: got v=%b idx=%0d expected v=1 idx=1", rr_valid, rr_idx);
    end
    req = 4'b0000;
    tick();
    vectors++;
    if ({rr_valid, rr_onehot, rr_idx, rr_busy} !== 8'h00) begin
      miscompares++;
      $display("FAIL drop_to_idle: got %b expected 00000000", {rr_valid, rr_onehot, rr_idx, rr_busy});
    end
    ack = 1'b0;
  endtask

  task automatic test_n3_wrap();
    int exp_seq [4] = '{1, 2, 0, 1};
    do_reset();
    req = 4'b0111;
    tick();
    vectors++;
    if (n3_valid !== 1'b1 || n3_idx !== 2'd0) begin
      miscompares++;
      $display("FAIL n3_first: got v=%b idx=%0d expected v=1 idx=0", n3_valid, n3_idx);
    end
    ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      vectors++;
      if (n3_valid !== 1'b1 || n3_idx !== 2'(exp_seq[k]) || n3_onehot !== (3'b001 << exp_seq[k])) begin
        miscompares++;
        $display("FAIL n3_wrap step %0d: got v=%b idx=%0d oh=%b expected v=1 idx=%0d", k, n3_valid, n3_idx, n3_onehot, exp_seq[k]);
      end
    end
    // Reset during a grant with ack high: ack must be ignored.
    reset = 1'b1;
    tick();
    vectors++;
    if (n3_valid !== 1'b0 || n3_idx !== 2'd0 || n3_onehot !== 3'b000 || n3_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL n3_mid_reset: got v=%b idx=%0d oh=%b expected v=0 idx=0 oh=000", n3_valid, n3_idx, n3_onehot);
    end
    reset = 1'b0;
    ack   = 1'b0;
    tick();
    vectors++;
    if (n3_valid !== 1'b1 || n3_idx !== 2'd0) begin
      miscompares++;
      $display("FAIL n3_post_reset: got v=%b idx=%0d expected v=1 idx=0", n3_valid, n3_idx);
    end
  endtask

`ifdef PRIO_ARBITER_STATS_EN
  task automatic test_stats();
    do_reset();
    req = 4'b0001;
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    tick();
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    ack = 1'b1;
    req = 4'b0000;
    tick();
    ack = 1'b0;
    vectors++;
    if (rr_cnt !== 16'd3) begin
      miscompares++;
      $display("FAIL grant_cnt: got %0d expected 3", rr_cnt);
    end
    vectors++;
    if (rr_wmax !== 8'd4) begin
      miscompares++;
      $display("FAIL wait_max: got %0d expected 4", rr_wmax);
    end
    req = 4'b0001;
    tick();
    ack = 1'b1;
    for (int k = 0; k < 70000; k++) begin
      tick();
    end
    ack = 1'b0;
    req = 4'b0000;
    vectors++;
    if (rr_cnt !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL grant_cnt_sat: got %h expected ffff", rr_cnt);
    end
    vectors++;
    if (rr_wmax !== 8'd4) begin
      miscompares++;
      $display("FAIL wait_max_keep: got %0d expected 4", rr_wmax);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    req   = 4'b0000;
    ack   = 1'b0;
    test_reset();
    test_fixed();
    test_back_to_back();
    test_no_preempt();
    test_idle_ack_and_drop();
    test_n3_wrap();
`ifdef PRIO_ARBITER_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
